test_status_device: RTL

// - Memory-mapped simulation responder on the core's data-memory store/load path; the core end of the bench<->core test handshake.
// - Decodes tohost-style pass/fail writes, buffers console bytes for the bench, and runs a cycle watchdog.
// - Raises DONE/PASS so the core testbench terminates on program outcome, not a fixed cycle count.
// - Sits beside data memory; the core's address decode steers BASE_ADDR..BASE_ADDR+0xF here.

---
 rtl/test_status_device_pkg.sv | 18 +
 rtl/test_status_device_console_fifo.sv | 60 ++++++
 rtl/test_status_device.sv | 121 ++++++++++++
 3 files changed

// File: rtl/test_status_device_pkg.sv
// Shared encodings and register map for the simulation test/status responder.
package test_status_device_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING   = 2'd0,
    ST_PASSED    = 2'd1,
    ST_FAILED    = 2'd2,
    ST_TIMED_OUT = 2'd3
  } test_state_t;

  localparam logic [31:0] TEST_DEV_BASE    = 32'h0000_F000;

  localparam logic [3:0]  TEST_TOHOST_OFS  = 4'h0;
  localparam logic [3:0]  TEST_CONSOLE_OFS = 4'h4;
  localparam logic [3:0]  TEST_CYCLE_OFS   = 4'h8;
  localparam logic [3:0]  TEST_STATUS_OFS  = 4'hC;

endpackage

// File: rtl/test_status_device_console_fifo.sv
// Console byte FIFO: head is visible combinationally from the storage flops, push/pop take effect at the edge.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic [WIDTH-1:0]         PUSH_DATA,
  input  logic                     POP,
  output logic [WIDTH-1:0]         HEAD,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign EMPTY = (wr_ptr_q == rd_ptr_q);
  assign FULL  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign COUNT = wr_ptr_q - rd_ptr_q;
  assign HEAD  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = POP && !EMPTY;
  assign do_push = PUSH && (!FULL || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = PUSH_DATA;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/test_status_device.sv
// Memory-mapped test responder: tohost pass/fail decode, console byte FIFO, cycle watchdog; loads return 1 cycle later.
// Console bytes are held for CHAR_READY; pushes into a full FIFO are dropped and flagged in STATUS.OVERFLOW.
module test_status_device
  import test_status_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = TEST_DEV_BASE,
  parameter int          TIMEOUT_CYCLES = 100_000,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] MEM_ADDR,
  input  logic        MEM_WR_EN,
  input  logic [31:0] MEM_WR_DATA,
  input  logic        MEM_RD_EN,
  output logic [31:0] MEM_RD_DATA,
  output logic        CHAR_VALID,
  output logic [7:0]  CHAR_DATA,
  input  logic        CHAR_READY,
  output logic        DONE,
  output logic        PASS,
  output logic [30:0] FAIL_CODE,
  output logic [31:0] CYCLE_COUNT
);

  localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  test_state_t state_q, state_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic [31:0] cycle_q, cycle_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic          hit, tohost_wr, console_wr;
  logic [3:0]    ofs;
  logic          fifo_empty, fifo_full, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_count8;
  logic          unused_addr_lsbs;

  assign hit              = (MEM_ADDR[31:4] == BASE_ADDR[31:4]);
  assign ofs              = {MEM_ADDR[3:2], 2'b00};
  assign unused_addr_lsbs = ^MEM_ADDR[1:0];
  assign tohost_wr        = hit && MEM_WR_EN && (ofs == TEST_TOHOST_OFS);
  assign console_wr       = hit && MEM_WR_EN && (ofs == TEST_CONSOLE_OFS);
  assign fifo_pop         = !fifo_empty && CHAR_READY;
  assign fifo_count8      = 8'(fifo_count);

  console_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .PUSH      (console_wr),
    .PUSH_DATA (MEM_WR_DATA[7:0]),
    .POP       (fifo_pop),
    .HEAD      (CHAR_DATA),
    .EMPTY     (fifo_empty),
    .FULL      (fifo_full),
    .COUNT     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    ovf_d       = ovf_q;
    rd_data_d   = '0;

    if (state_q == ST_RUNNING) begin
      if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
      // An outcome write in the same cycle as the timeout takes priority.
      if (tohost_wr && MEM_WR_DATA[0]) begin
        if (MEM_WR_DATA == 32'd1) begin
          state_d = ST_PASSED;
        end else begin
          state_d     = ST_FAILED;
          fail_code_d = MEM_WR_DATA[31:1];
        end
      end else if (cycle_q == TIMEOUT_LAST) begin
        state_d = ST_TIMED_OUT;
      end
    end

    if (console_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;

    if (hit && MEM_RD_EN) begin
      case (ofs)
        TEST_CYCLE_OFS:  rd_data_d = cycle_q;
        TEST_STATUS_OFS: rd_data_d = {ovf_q, 15'd0, fifo_count8, 6'd0, state_q};
        default:         rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUNNING;
      fail_code_q <= '0;
      cycle_q     <= '0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign MEM_RD_DATA = rd_data_q;
  assign CHAR_VALID  = !fifo_empty;
  assign DONE        = (state_q != ST_RUNNING);
  assign PASS        = (state_q == ST_PASSED);
  assign FAIL_CODE   = fail_code_q;
  assign CYCLE_COUNT = cycle_q;

endmodule
